// File: rtl/median_ctrl.sv
// median_ctrl: address/sequencing controller for a 3x3 binary median filter.
//
// Pixels arrive one per pix_valid strobe and are written to a frame RAM in raster
// order. Once two lines plus three pixels are stored, every new pixel also issues
// one 3x3 window read (rd_addr is the window's top-left pixel; the datapath adds
// the eight other offsets). After the last pixel is written, the remaining windows
// are read back-to-back. med_in, the majority vote of the nine RAM outputs, is
// registered into med_out two cycles after the window read.
//
// Ports:
//   guass_clk   in   clock, rising edge
//   CMOS_VSYNC  in   asynchronous active-high reset and frame restart
//   pix_valid   in   input pixel strobe
//   med_in      in   majority of the nine window RAM outputs (1 cycle after read)
//   wr_en       out  RAM write enable
//   wr_addr     out  RAM write address (18 bits)
//   rd_addr     out  window top-left read address (18 bits)
//   win_valid   out  window read issued this cycle
//   out_valid   out  med_out valid
//   med_out     out  filtered pixel
//   border      out  med_out belongs to a window touching the right/bottom edge
//   frame_done  out  one-cycle pulse with the frame's last out_valid
//
// Build option: define MEDIAN_BORDER_ZERO_EN to force med_out to 0 for border
// windows; otherwise border is informational only.

module median_ctrl #(
  parameter int unsigned H_ACT = 320,
  parameter int unsigned V_ACT = 480
) (
  input  logic        guass_clk,
  input  logic        CMOS_VSYNC,
  input  logic        pix_valid,
  input  logic        med_in,
  output logic        wr_en,
  output logic [17:0] wr_addr,
  output logic [17:0] rd_addr,
  output logic        win_valid,
  output logic        out_valid,
  output logic        med_out,
  output logic        border,
  output logic        frame_done
);

  localparam int unsigned AW = 18;
  localparam int unsigned CW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int unsigned RW = (V_ACT > 1) ? $clog2(V_ACT) : 1;

  // Last write of the fill phase: after it, 2*H_ACT+3 pixels are stored.
  localparam logic [AW-1:0] FillLast = AW'(2 * H_ACT + 2);
  localparam logic [AW-1:0] PixLast  = AW'(H_ACT * V_ACT - 1);
  localparam logic [CW-1:0] ColLast  = CW'(H_ACT - 1);
  localparam logic [RW-1:0] RowLast  = RW'(V_ACT - 1);
  localparam logic [CW-1:0] ColEdge  = CW'(H_ACT - 2);
  localparam logic [RW-1:0] RowEdge  = RW'(V_ACT - 2);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRun,
    StFlush,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          valid_q1, out_valid_q;
  logic          border_q1, border_q2;
  logic          last_q1, frame_done_q;
  logic          med_q;

  logic          wr_en_c;
  logic          win_valid_c;
  logic          win_border;
  logic          last_rd;

  // Next state and per-cycle strobes.
  always_comb begin
    state_d     = state_q;
    wr_en_c     = 1'b0;
    win_valid_c = 1'b0;
    unique case (state_q)
      StIdle: begin
        wr_en_c = pix_valid;
        if (pix_valid) state_d = StFill;
      end
      StFill: begin
        wr_en_c = pix_valid;
        if (pix_valid && (wr_ptr_q == FillLast)) state_d = StRun;
      end
      StRun: begin
        // Read pointer trails the write pointer by exactly 2*H_ACT+3, so the
        // window's bottom-right pixel is always already stored.
        wr_en_c     = pix_valid;
        win_valid_c = pix_valid;
        if (pix_valid && (wr_ptr_q == PixLast)) state_d = StFlush;
      end
      StFlush: begin
        win_valid_c = 1'b1;
        if (rd_ptr_q == PixLast) state_d = StDone;
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  assign win_border = (col_q >= ColEdge) || (row_q >= RowEdge);
  assign last_rd    = win_valid_c && (rd_ptr_q == PixLast);

  always_ff @(posedge guass_clk or posedge CMOS_VSYNC) begin
    if (CMOS_VSYNC) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      valid_q1     <= 1'b0;
      out_valid_q  <= 1'b0;
      border_q1    <= 1'b0;
      border_q2    <= 1'b0;
      last_q1      <= 1'b0;
      frame_done_q <= 1'b0;
      med_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (win_valid_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        // col/row follow rd_addr without a divider.
        if (col_q == ColLast) begin
          col_q <= '0;
          row_q <= (row_q == RowLast) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      valid_q1     <= win_valid_c;
      out_valid_q  <= valid_q1;
      border_q1    <= win_valid_c & win_border;
      border_q2    <= border_q1;
      last_q1      <= last_rd;
      frame_done_q <= last_q1;
`ifdef MEDIAN_BORDER_ZERO_EN
      med_q        <= med_in & ~border_q1;
`else
      med_q        <= med_in;
`endif
    end
  end

  // Strobes are gated so they drop the moment CMOS_VSYNC rises.
  assign wr_en      = wr_en_c & ~CMOS_VSYNC;
  assign win_valid  = win_valid_c & ~CMOS_VSYNC;
  assign wr_addr    = wr_ptr_q;
  assign rd_addr    = rd_ptr_q;
  assign out_valid  = out_valid_q;
  assign border     = border_q2;
  assign frame_done = frame_done_q;
  assign med_out    = med_q;

endmodule

// File: doc/median_ctrl.md
MEDIAN_CTRL -- requirements
Module: median_ctrl

Interface
REQ-001 SHALL have parameter H_ACT, default 320, meaning active pixels per line.
REQ-002 SHALL have parameter V_ACT, default 480, meaning active lines per frame; frame size N = H_ACT*V_ACT = 153600.
REQ-003 SHALL have port guass_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port CMOS_VSYNC, input, 1, the reset: asynchronous, active-high, and also the frame restart.
REQ-005 SHALL have port pix_valid, input, 1, binary input pixel strobe for the current cycle.
REQ-006 SHALL have port med_in, input, 1, majority result from the nine window RAM outputs.
REQ-007 SHALL have port wr_en, output, 1, RAM write enable.
REQ-008 SHALL have port wr_addr, output, 18, RAM write address.
REQ-009 SHALL have port rd_addr, output, 18, window top-left read address; the datapath adds offsets 0,1,2,320,321,322,640,641,642.
REQ-010 SHALL have port win_valid, output, 1, window read issued this cycle.
REQ-011 SHALL have port out_valid, output, 1, med_out valid.
REQ-012 SHALL have port med_out, output, 1, filtered pixel.
REQ-013 SHALL have port border, output, 1, med_out belongs to a border window.
REQ-014 SHALL have port frame_done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-015 SHALL implement FSM IDLE, FILL, RUN, FLUSH, DONE.
REQ-016 IDLE SHALL go to FILL on the first pix_valid and write that pixel in the same cycle.
REQ-017 In IDLE, FILL and RUN, wr_en SHALL equal pix_valid; wr_addr SHALL increment after each write and not wrap within a frame.
REQ-018 FILL SHALL count writes; when write count reaches 643 (2*H_ACT+3), it SHALL go to RUN.
REQ-019 In RUN, each pix_valid SHALL also issue one read: win_valid=1 and rd_addr=current read pointer. The read pointer SHALL then increment, keeping rd_addr+642 strictly below the written count.
REQ-020 When write N-1 occurs, the FSM SHALL go to FLUSH.
REQ-021 FLUSH SHALL issue one read per clock, independent of pix_valid, with wr_en=0, until read N-1 is issued, then go to DONE.
REQ-022 Each frame SHALL produce exactly N win_valid cycles with rd_addr 0..N-1 in order.
REQ-023 DONE SHALL pulse frame_done for one cycle, two cycles after the last read, aligned with the last out_valid.
REQ-024 DONE SHALL ignore pix_valid, keep wr_en=0, and stay in DONE until CMOS_VSYNC.
REQ-025 SHALL keep col (0..H_ACT-1) and row (0..V_ACT-1) counters tracking rd_addr, with col wrapping to 0 and row incrementing; no divider.
REQ-026 A window SHALL be border when col >= H_ACT-2 or row >= V_ACT-2.
REQ-027 Output latency SHALL be fixed:
 - RAM read latency is 1: med_in is valid in the cycle after win_valid.
 - med_in SHALL be registered into med_out.
 - out_valid and border SHALL equal win_valid and border delayed 2 cycles.
REQ-028 Write and read in the same cycle (RUN) SHALL both proceed; no priority is needed.

Reset
REQ-029 While CMOS_VSYNC=1 (asynchronous), outputs and state SHALL reset:
 - FSM=IDLE; all counters, wr_addr, rd_addr=0;
 - wr_en, win_valid, out_valid, med_out, border, frame_done=0.
REQ-030 CMOS_VSYNC asserted in any state, including mid-FILL, RUN or FLUSH, SHALL abort the frame with no frame_done, and the next frame SHALL restart from IDLE.
REQ-031 pix_valid during the CMOS_VSYNC release cycle SHALL be accepted as pixel 0.

Configuration
REQ-032 With macro MEDIAN_BORDER_ZERO_EN defined, med_out SHALL be forced to 0 whenever the delayed border flag is 1.
REQ-033 Without MEDIAN_BORDER_ZERO_EN, med_out SHALL be med_in registered, and border SHALL remain informational only.

Verification
REQ-034 Continuous pix_valid, 153600 pixels: first win_valid on cycle 643, with rd_addr=0 and wr_addr=643; exactly 153600 win_valid; frame_done on the cycle of the last out_valid.
REQ-035 pix_valid 50% duty in RUN: win_valid only on pix_valid cycles; rd_addr is always 643 below the post-write count.
REQ-036 All-ones image with MEDIAN_BORDER_ZERO_EN: med_out=0 at rd_addr 318, 319, 152960..153599; med_out=1 at rd_addr 0 and 317. Without the macro: all 1.
REQ-037 CMOS_VSYNC pulsed at write 80000: all outputs 0 immediately; no frame_done; the next full frame completes normally.
REQ-038 pix_valid held high in DONE: wr_en stays 0 and wr_addr stays 153600 (not wrapped) until CMOS_VSYNC.
